i2c_slave_ctl: RTL and testbench
================================

I2C_SLAVE_CTL -- requirements
Module: i2c_slave_ctl

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4: number of consecutive equal sysclk samples required before filtered SCL/SDA change (1..15).
REQ-002 SHALL have port i_sysclk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port i_reset_n  input  1  reset; one clock, reset asynchronous active-low.
REQ-004 SHALL have port i_enable  input  1  slave enable; low forces IDLE and releases both lines within 1 cycle.
REQ-005 SHALL have port i_slave_addr  input  7  own 7-bit address.
REQ-006 SHALL have ports i_scl, i_sda  input  1 each  pad inputs.
REQ-007 SHALL have port o_sda_oen  output  1  SDA output enable, active-low; pad drives 0 only, never 1.
REQ-008 SHALL have port o_scl_oen  output  1  SCL output enable, active-low (stretch only).
REQ-009 SHALL have ports o_rx_data  output  8  and o_rx_valid  output  1  received byte and 1-cycle strobe.
REQ-010 SHALL have ports i_tx_data  input  8  and o_tx_req  output  1  byte to transmit and 1-cycle request strobe.
REQ-011 SHALL have ports o_start, o_stop  output  1 each  1-cycle bus-condition strobes; o_rw  output  1  R/W bit of last matched address; o_busy  output  1  high while addressed.
REQ-012 SHALL have port i_hold  input  1  stretch request (used only under I2C_SLAVE_CLK_STRETCH_EN).

Function
REQ-013 SHALL pass i_scl/i_sda through 2-flop sync then FILTER_LEN filter; edges below derived from filtered values only.
REQ-014 SHALL detect START as filtered SDA fall while SCL high, STOP as SDA rise while SCL high; each pulses o_start/o_stop 1 cycle after detection.
REQ-015 SHALL use states IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
REQ-016 SHALL go to ADDR on START or repeated START from any state, clearing the bit counter; STOP from any state goes to IDLE, o_busy=0, lines released.
REQ-017 SHALL sample SDA on filtered SCL rise and change o_sda_oen only on filtered SCL fall; bits MSB first, 3-bit counter wraps after bit 0.
REQ-018 SHALL on 8th address bit compare [7:1] to i_slave_addr: match -> ADDR_ACK, latch o_rw, o_busy=1; mismatch -> WAIT_STOP, SDA never driven.
REQ-019 SHALL in ADDR_ACK/RX_ACK drive SDA low from the SCL fall after bit 0 until the next SCL fall.
REQ-020 SHALL after ADDR_ACK enter RX if o_rw=0, TX if o_rw=1; in RX, load o_rx_data and pulse o_rx_valid 1 cycle after the SCL rise sampling bit 0.
REQ-021 SHALL pulse o_tx_req on the SCL rise of ADDR_ACK (rw=1) or of a TX_ACK sampled low, and capture i_tx_data at the following SCL fall.
REQ-022 SHALL in TX_ACK release SDA; master ACK (0) -> TX, NAK (1) -> WAIT_STOP.
REQ-023 SHALL treat simultaneous START and bit sampling as START; STOP mid-byte discards the partial byte, no o_rx_valid.

Reset
REQ-024 SHALL while i_reset_n low: state IDLE, o_sda_oen=1, o_scl_oen=1, o_rx_data=8'h00, o_rx_valid/o_tx_req/o_start/o_stop=0, o_rw=0, o_busy=0, filters and syncs preset to 1 (no false START on release).

Configuration
REQ-025 SHALL, with I2C_SLAVE_CLK_STRETCH_EN defined, drive o_scl_oen=0 from the SCL fall ending any ACK bit while i_hold=1, releasing 1 cycle after i_hold=0; bit timing resumes from released SCL.
REQ-026 SHALL, without I2C_SLAVE_CLK_STRETCH_EN, tie o_scl_oen=1 and ignore i_hold.

Structure
REQ-027 SHALL place state encodings and ACK/NAK constants in shared include i2c-def.v alongside master definitions.
REQ-028 SHALL instantiate sub-module i2c_in_filter (sync + FILTER_LEN filter) once for SCL, once for SDA.

Verification
REQ-029 SHALL test write: addr 0x50, master sends 0xA0, 0x3C, STOP -> both bytes ACKed, o_rx_valid once with o_rx_data=0x3C, o_stop pulse, o_busy=0.
REQ-030 SHALL test read: master sends 0xA1, i_tx_data=0x96, master NAK -> SDA bits 1,0,0,1,0,1,1,0, one o_tx_req, state WAIT_STOP, SDA released.
REQ-031 SHALL test mismatch: master sends 0xA2 -> o_sda_oen stays 1 through ACK slot, o_busy=0, no strobes except o_start.
REQ-032 SHALL test repeated START after 4 bits of RX byte, then 0xA1 -> no o_rx_valid, o_rw=1, ADDR_ACK driven.
REQ-033 SHALL test filter: 2-cycle low glitch on SCL with FILTER_LEN=4 -> no bit sampled, counter unchanged.
REQ-034 SHALL test stretch (macro on): i_hold=1 for 50 cycles after address ACK -> o_scl_oen=0 for those cycles, released 1 cycle after i_hold falls.

Source files
------------

// File: rtl/i2c_slave_ctl_pkg.sv
// i2c_slave_ctl_pkg -- bus-level definitions shared by the I2C slave controller
// and its input filter: controller state encoding and ACK/NAK line levels.
package i2c_slave_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK,
    WAIT_STOP
  } i2c_state_t;

  // SDA level during the acknowledge bit
  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NAK = 1'b1;

  // width of the glitch-filter run-length counter (FILTER_LEN up to 15)
  localparam int unsigned FILTER_CNT_W = 4;

endpackage

// File: rtl/i2c_slave_ctl_in_filter.sv
// i2c_in_filter -- pad input conditioner: 2-flop synchroniser followed by a
// run-length filter. The output only follows the synchronised input after
// FILTER_LEN consecutive samples that disagree with the current output.
// Ports:
//   i_sysclk, i_reset_n : clock, asynchronous active-low reset
//   i_pad               : raw pad input
//   o_filt              : filtered level (presets to 1 so an idle bus stays idle)
module i2c_in_filter
  import i2c_slave_ctl_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic i_sysclk,
  input  logic i_reset_n,
  input  logic i_pad,
  output logic o_filt
);

  logic [1:0]              sync;
  logic [FILTER_CNT_W-1:0] run_cnt;

  always_ff @(posedge i_sysclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync    <= '1;
      o_filt  <= 1'b1;
      run_cnt <= '0;
    end else begin
      sync <= {sync[0], i_pad};
      if (sync[1] == o_filt) begin
        run_cnt <= '0;
      end else if (run_cnt == FILTER_CNT_W'(FILTER_LEN - 1)) begin
        o_filt  <= sync[1];
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_ctl.sv
// i2c_slave_ctl -- 7-bit-address I2C slave protocol controller.
// Ports:
//   i_sysclk, i_reset_n      : clock, asynchronous active-low reset
//   i_enable                 : slave enable; low forces IDLE and releases the bus
//   i_slave_addr             : own 7-bit address
//   i_scl, i_sda             : pad inputs
//   o_sda_oen, o_scl_oen     : active-low open-drain enables (pad drives 0 only)
//   o_rx_data, o_rx_valid    : received byte and its 1-cycle strobe
//   i_tx_data, o_tx_req      : byte to transmit and its 1-cycle request strobe
//   o_start, o_stop          : 1-cycle bus-condition strobes
//   o_rw, o_busy             : R/W bit of last matched address, addressed flag
//   i_hold                   : clock-stretch request
// Build option: I2C_SLAVE_CLK_STRETCH_EN enables SCL stretching after ACK bits;
// otherwise o_scl_oen is tied high and i_hold is ignored.
module i2c_slave_ctl
  import i2c_slave_ctl_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic       i_sysclk,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic [6:0] i_slave_addr,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oen,
  output logic       o_scl_oen,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_req,
  output logic       o_start,
  output logic       o_stop,
  output logic       o_rw,
  output logic       o_busy,
  input  logic       i_hold
);

  logic       f_scl, f_sda, scl_q, sda_q;
  logic       scl_rise, scl_fall, start_det, stop_det, ack_end;
  i2c_state_t state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sh, tx_sh;
  logic       ack_clk;  // SCL rise of the current ACK bit already seen

  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .i_sysclk (i_sysclk), .i_reset_n(i_reset_n), .i_pad(i_scl), .o_filt(f_scl)
  );
  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .i_sysclk (i_sysclk), .i_reset_n(i_reset_n), .i_pad(i_sda), .o_filt(f_sda)
  );

  always_ff @(posedge i_sysclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= f_scl;
      sda_q <= f_sda;
    end
  end

  always_comb begin
    scl_rise  = f_scl & ~scl_q;
    scl_fall  = ~f_scl & scl_q;
    start_det = scl_q & f_scl & sda_q & ~f_sda;
    stop_det  = scl_q & f_scl & ~sda_q & f_sda;
    ack_end   = scl_fall & ack_clk &
                ((state == ADDR_ACK) | (state == RX_ACK) | (state == TX_ACK));
  end

  always_ff @(posedge i_sysclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      ack_clk    <= 1'b0;
      o_sda_oen  <= 1'b1;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
      o_tx_req   <= 1'b0;
      o_start    <= 1'b0;
      o_stop     <= 1'b0;
      o_rw       <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      o_tx_req   <= 1'b0;
      if (!i_enable) begin
        state     <= IDLE;
        o_sda_oen <= 1'b1;
        o_busy    <= 1'b0;
        o_start   <= 1'b0;
        o_stop    <= 1'b0;
      end else begin
        o_start <= start_det;
        o_stop  <= stop_det;
        // START wins over any bit sampled in the same cycle
        if (start_det) begin
          state     <= ADDR;
          bit_cnt   <= '0;
          o_sda_oen <= 1'b1;
          o_busy    <= 1'b0;
        end else if (stop_det) begin
          state     <= IDLE;
          o_sda_oen <= 1'b1;
          o_busy    <= 1'b0;
        end else begin
          case (state)
            ADDR: if (scl_rise) begin
              rx_sh   <= {rx_sh[5:0], f_sda};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (rx_sh == i_slave_addr) begin
                  state   <= ADDR_ACK;
                  ack_clk <= 1'b0;
                  o_rw    <= f_sda;
                  o_busy  <= 1'b1;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end
            ADDR_ACK, RX_ACK: begin
              if (scl_rise) begin
                ack_clk <= 1'b1;
                if (state == ADDR_ACK && o_rw) o_tx_req <= 1'b1;
              end
              if (scl_fall) begin
                if (!ack_clk) begin
                  o_sda_oen <= I2C_ACK;
                end else if (state == ADDR_ACK && o_rw) begin
                  state     <= TX;
                  bit_cnt   <= '0;
                  tx_sh     <= i_tx_data[6:0];
                  o_sda_oen <= i_tx_data[7];
                end else begin
                  state     <= RX;
                  bit_cnt   <= '0;
                  o_sda_oen <= 1'b1;
                end
              end
            end
            RX: if (scl_rise) begin
              rx_sh   <= {rx_sh[5:0], f_sda};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                o_rx_data  <= {rx_sh, f_sda};
                o_rx_valid <= 1'b1;
                state      <= RX_ACK;
                ack_clk    <= 1'b0;
              end
            end
            TX: begin
              // bit 7 went out on entry; the remaining seven follow on SCL falls
              if (scl_fall) begin
                o_sda_oen <= tx_sh[6];
                tx_sh     <= {tx_sh[5:0], 1'b0};
              end
              if (scl_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  state   <= TX_ACK;
                  ack_clk <= 1'b0;
                end
              end
            end
            TX_ACK: begin
              if (scl_rise) begin
                if (f_sda == I2C_NAK) begin
                  state <= WAIT_STOP;
                end else begin
                  ack_clk  <= 1'b1;
                  o_tx_req <= 1'b1;
                end
              end
              if (scl_fall) begin
                if (!ack_clk) begin
                  o_sda_oen <= 1'b1;
                end else begin
                  state     <= TX;
                  bit_cnt   <= '0;
                  tx_sh     <= i_tx_data[6:0];
                  o_sda_oen <= i_tx_data[7];
                end
              end
            end
            default: o_sda_oen <= 1'b1;
          endcase
        end
      end
    end
  end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  // Stretch begins on the SCL fall that ends an ACK bit and lasts while i_hold
  always_ff @(posedge i_sysclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_scl_oen <= 1'b1;
    end else if (!i_enable || start_det || stop_det) begin
      o_scl_oen <= 1'b1;
    end else if (ack_end) begin
      o_scl_oen <= ~i_hold;
    end else if (!i_hold) begin
      o_scl_oen <= 1'b1;
    end
  end
`else
  logic unused_hold;
  assign unused_hold = i_hold ^ ack_end;
  assign o_scl_oen   = 1'b1;
`endif

endmodule

// File: tb/tb_i2c_slave_ctl.sv
module tb_i2c_slave_ctl;

  localparam int Q    = 10;  // quarter bit period in sysclk cycles
  localparam int NVEC = 13;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, en, hold, m_scl, m_sda;
  logic [6:0] own;
  logic [7:0] txd;
  logic       scl_line, sda_line;
  logic       o_sda_oen, o_scl_oen, o_rx_valid, o_tx_req, o_start, o_stop, o_rw, o_busy;
  logic [7:0] o_rx_data;

  always #5 clk = ~clk;

  assign scl_line = m_scl & o_scl_oen;
  assign sda_line = m_sda & o_sda_oen;

  i2c_slave_ctl #(.FILTER_LEN(4)) dut (
    .i_sysclk(clk), .i_reset_n(rst_n), .i_enable(en), .i_slave_addr(own),
    .i_scl(scl_line), .i_sda(sda_line), .o_sda_oen(o_sda_oen), .o_scl_oen(o_scl_oen),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .i_tx_data(txd), .o_tx_req(o_tx_req),
    .o_start(o_start), .o_stop(o_stop), .o_rw(o_rw), .o_busy(o_busy), .i_hold(hold)
  );

  int unsigned n_rxv = 0, n_txr = 0, n_start = 0, n_stop = 0;
  logic [7:0]  last_rx = '0;
  always @(negedge clk) begin
    if (o_rx_valid) begin n_rxv++; last_rx = o_rx_data; end
    if (o_tx_req) n_txr++;
    if (o_start)  n_start++;
    if (o_stop)   n_stop++;
  end

  int n_vec = 0, n_mis = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scl_hi();
    int k = 0;
    m_scl = 1'b1;
    while (scl_line !== 1'b1 && k < 2000) begin tick(1); k++; end
    if (k >= 2000) check("scl_release_timeout", scl_line, 1);
  endtask

  task automatic xfer_bit(input logic b, input logic glitch, output logic rd);
    m_sda = b; tick(Q);
    scl_hi();
    if (glitch) begin tick(Q); m_scl = 1'b0; tick(2); m_scl = 1'b1; end
    tick(Q);
    rd = sda_line;
    tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic xfer_byte(input logic [7:0] b, input int glitch_bit, output logic [7:0] rd);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(b[i], glitch_bit == i, r);
      rd[i] = r;
    end
  endtask

  task automatic do_start();
    m_sda = 1'b1; tick(Q);
    scl_hi(); tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic do_stop();
    m_sda = 1'b0; tick(Q);
    scl_hi(); tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  typedef struct {
    logic [6:0]  own;
    logic [7:0]  addr;
    int unsigned nbytes;
    logic [23:0] data;
    logic        exp_ack;
    int unsigned exp_rxv;
    int unsigned exp_txr;
    logic [7:0]  exp_last;
  } vec_t;

  function automatic logic [7:0] byte_of(input logic [23:0] d, input int unsigned k);
    return d[(23 - 8 * k) -: 8];
  endfunction

  // Transaction-level expectations: addressed iff the upper 7 bits match; a
  // write yields one rx strobe per byte, a read one tx request per byte.
  function automatic vec_t mk(input logic [6:0] o, input logic [7:0] a,
                              input int unsigned n, input logic [23:0] d);
    vec_t v;
    v.own = o; v.addr = a; v.nbytes = n; v.data = d;
    v.exp_ack  = (a[7:1] == o);
    v.exp_rxv  = (v.exp_ack && !a[0]) ? n : 0;
    v.exp_txr  = (v.exp_ack && a[0]) ? n : 0;
    v.exp_last = byte_of(d, n - 1);
    return v;
  endfunction

  vec_t        tbl [NVEC];
  logic        a;
  logic [7:0]  rd;
  int unsigned s_rxv, s_txr, s_st, s_sp;
  int          cnt;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(7'h50, 8'hA0, 1, 24'h3C0000);
    tbl[1] = mk(7'h50, 8'hA1, 1, 24'h960000);
    tbl[2] = mk(7'h50, 8'hA2, 1, 24'h550000);
    for (int i = 3; i < NVEC; i++) begin
      logic [6:0] o;
      logic [7:0] ad;
      o  = 7'($urandom);
      ad = ($urandom_range(0, 3) != 0) ? {o, 1'($urandom)} : 8'($urandom);
      tbl[i] = mk(o, ad, $urandom_range(1, 3), 24'($urandom));
    end

    // reset
    rst_n = 1'b0; en = 1'b1; hold = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
    own = 7'h50; txd = 8'h00;
    tick(3);
    check("rst_sda_oen", o_sda_oen, 1);
    check("rst_scl_oen", o_scl_oen, 1);
    check("rst_rx_data", o_rx_data, 8'h00);
    check("rst_strobes", {o_rx_valid, o_tx_req, o_start, o_stop}, 4'b0000);
    check("rst_rw_busy", {o_rw, o_busy}, 2'b00);
    rst_n = 1'b1;
    tick(20);
    check("no_false_start", n_start, 0);

    // table-driven transactions
    for (int i = 0; i < NVEC; i++) begin
      vec_t v;
      v = tbl[i];
      own = v.own; txd = byte_of(v.data, 0);
      s_rxv = n_rxv; s_txr = n_txr; s_st = n_start; s_sp = n_stop;
      do_start();
      xfer_byte(v.addr, -1, rd);
      xfer_bit(1'b1, 1'b0, a);
      check("addr_ack", a, v.exp_ack ? 0 : 1);
      check("busy_addressed", o_busy, v.exp_ack);
      if (v.exp_ack) check("rw_latched", o_rw, v.addr[0]);
      if (!v.addr[0]) begin
        for (int unsigned k = 0; k < v.nbytes; k++) begin
          xfer_byte(byte_of(v.data, k), -1, rd);
          xfer_bit(1'b1, 1'b0, a);
          check("data_ack", a, v.exp_ack ? 0 : 1);
        end
      end else begin
        for (int unsigned k = 0; k < v.nbytes; k++) begin
          xfer_byte(8'hFF, -1, rd);
          check("read_byte", rd, v.exp_ack ? byte_of(v.data, k) : 8'hFF);
          if (k + 1 < v.nbytes) txd = byte_of(v.data, k + 1);
          xfer_bit(k + 1 == v.nbytes, 1'b0, a);
        end
        xfer_byte(8'hFF, -1, rd);
        check("released_after_nak", rd, 8'hFF);
        xfer_bit(1'b1, 1'b0, a);
      end
      do_stop();
      tick(Q);
      check("rx_valid_count", n_rxv - s_rxv, v.exp_rxv);
      check("tx_req_count", n_txr - s_txr, v.exp_txr);
      check("start_count", n_start - s_st, 1);
      check("stop_count", n_stop - s_sp, 1);
      check("busy_after_stop", o_busy, 0);
      if (v.exp_rxv != 0) check("last_rx_data", last_rx, v.exp_last);
    end

    // repeated START four bits into a write byte, then a read
    own = 7'h50; txd = 8'hC3;
    s_rxv = n_rxv; s_st = n_start;
    do_start();
    xfer_byte(8'hA0, -1, rd);
    xfer_bit(1'b1, 1'b0, a);
    check("rs_first_ack", a, 0);
    for (int i = 0; i < 4; i++) xfer_bit(i[0], 1'b0, a);
    do_start();
    xfer_byte(8'hA1, -1, rd);
    xfer_bit(1'b1, 1'b0, a);
    check("rs_addr_ack", a, 0);
    check("rs_rw", o_rw, 1);
    xfer_byte(8'hFF, -1, rd);
    check("rs_read_byte", rd, 8'hC3);
    xfer_bit(1'b1, 1'b0, a);
    do_stop(); tick(Q);
    check("rs_no_rx_valid", n_rxv - s_rxv, 0);
    check("rs_start_count", n_start - s_st, 2);

    // 2-cycle SCL low glitch during address bit 5 must not add a sample
    s_rxv = n_rxv;
    do_start();
    xfer_byte(8'hA0, 5, rd);
    xfer_bit(1'b1, 1'b0, a);
    check("glitch_addr_ack", a, 0);
    xfer_byte(8'h11, -1, rd);
    xfer_bit(1'b1, 1'b0, a);
    do_stop(); tick(Q);
    check("glitch_rx_count", n_rxv - s_rxv, 1);
    check("glitch_rx_data", last_rx, 8'h11);

    // ACK is driven before the ACK clock; disable releases within one cycle
    do_start();
    xfer_byte(8'hA0, -1, rd);
    m_sda = 1'b1;
    check("ack_driven_early", o_sda_oen, 0);
    en = 1'b0; tick(1);
    check("disable_release", o_sda_oen, 1);
    check("disable_busy", o_busy, 0);
    en = 1'b1; tick(Q);
    s_sp = n_stop;
    do_stop(); tick(Q);
    check("stop_after_enable", n_stop - s_sp, 1);

    // clock stretch after address ACK
    s_rxv = n_rxv;
    do_start();
    xfer_byte(8'hA0, -1, rd);
    hold = 1'b1;
    xfer_bit(1'b1, 1'b0, a);
    check("stretch_addr_ack", a, 0);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (o_scl_oen == 1'b0) cnt++;
      tick(1);
    end
    check("stretch_low_cycles", cnt, STRETCH ? 50 : 0);
    hold = 1'b0;
    check("stretch_at_hold_fall", o_scl_oen, STRETCH ? 0 : 1);
    tick(1);
    check("stretch_released", o_scl_oen, 1);
    xfer_byte(8'h5A, -1, rd);
    xfer_bit(1'b1, 1'b0, a);
    check("stretch_data_ack", a, 0);
    do_stop(); tick(Q);
    check("stretch_rx_data", last_rx, 8'h5A);
    check("stretch_rx_count", n_rxv - s_rxv, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
